// File: rtl/mbs_pkg.sv
// mbs_pkg: shared FSM encoding and sizing helper for the shift-add multiplier.
package mbs_pkg;
  localparam logic [1:0] OCIOSO   = 2'd0;
  localparam logic [1:0] CALCULA  = 2'd1;
  localparam logic [1:0] FINALIZA = 2'd2;
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/mbs_param_if.sv
// mbs_param_if: start/busy/done handshake and operand/result bus of the multiplier.
interface mbs_param_if #(parameter int WIDTH = 8);
  logic               iniciar;
  logic               com_sinal;
  logic [WIDTH-1:0]   multiplicando;
  logic [WIDTH-1:0]   multiplicador;
  logic               ocupado;
  logic               pronto;
  logic [2*WIDTH-1:0] produto;
  modport master (output iniciar, com_sinal, multiplicando, multiplicador,
                  input  ocupado, pronto, produto);
  modport slave  (input  iniciar, com_sinal, multiplicando, multiplicador,
                  output ocupado, pronto, produto);
endinterface

// File: rtl/mbs_magnitude.sv
// mbs_magnitude: magnitude and sign of an operand; the most negative value maps to 2^(WIDTH-1).
module mbs_magnitude #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] value,
  input  logic             sgn,
  output logic [WIDTH-1:0] mag,
  output logic             neg
);
  always_comb begin
    neg = sgn & value[WIDTH-1];
    mag = neg ? -value : value;
  end
endmodule

// File: rtl/mbs_param.sv
// mbs_param: sequential shift-add multiplier, signed or unsigned per operation, optional early exit.
module mbs_param
  import mbs_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 0
) (
  input  logic        clock,
  input  logic        reset,
  mbs_param_if.slave  bus
);
  localparam int CW = cnt_width(WIDTH);
  logic [1:0]         state;
  logic [WIDTH-1:0]   mult, mult_n, mag_a, mag_b;
  logic [2*WIDTH-1:0] mcand, acc, produto;
  logic [CW-1:0]      cnt, cnt_n;
  logic               neg, neg_a, neg_b, pronto, done;
  mbs_magnitude #(.WIDTH(WIDTH)) u_mag_a (
    .value(bus.multiplicando), .sgn(bus.com_sinal), .mag(mag_a), .neg(neg_a)
  );
  mbs_magnitude #(.WIDTH(WIDTH)) u_mag_b (
    .value(bus.multiplicador), .sgn(bus.com_sinal), .mag(mag_b), .neg(neg_b)
  );
  always_comb begin
    mult_n = mult >> 1;
    cnt_n  = cnt - 1'b1;
    done   = (cnt_n == '0) || ((EARLY_EXIT != 0) && (mult_n == '0));
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= OCIOSO;
      mult    <= '0;
      mcand   <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      produto <= '0;
      pronto  <= 1'b0;
    end else begin
      pronto <= 1'b0;
      if (state == OCIOSO) begin
        if (bus.iniciar) begin
          mcand <= {{WIDTH{1'b0}}, mag_a};
          mult  <= mag_b;
          neg   <= neg_a ^ neg_b;
          acc   <= '0;
          cnt   <= CW'(WIDTH);
          state <= CALCULA;
        end
      end else if (state == CALCULA) begin
        if (mult[0]) acc <= acc + mcand;
        mult  <= mult_n;
        mcand <= mcand << 1;
        cnt   <= cnt_n;
        state <= done ? FINALIZA : CALCULA;
      end else if (state == FINALIZA) begin
        produto <= neg ? -acc : acc;
        pronto  <= 1'b1;
        state   <= OCIOSO;
      end else begin
        state <= OCIOSO;
      end
    end
  end
  assign bus.ocupado = (state != OCIOSO);
  assign bus.pronto  = pronto;
  assign bus.produto = produto;
endmodule
